// File: rtl/tight_acc_mem_pkg.sv
// ============================================================================
// Module : tight_acc_mem_pkg
// Brief  : Shared types, constants and the line-pattern helper for the tight
//          accelerator memory responder.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Contents:
//   LINE_OFFS    byte offset bits inside a 64-byte line
//   LINE_W_MAX   widest supported line address (PADDR_W up to PADDR_W_MAX)
//   RESP_W_MAX   widest supported response (RESP_W must be below this)
//   rsp_entry_t  one queued request: transid, line address, wait counter
//   line_pattern address-derived line contents
// ============================================================================
`default_nettype none

package tight_acc_mem_pkg;

  localparam int LINE_OFFS   = 6;
  localparam int PADDR_W_MAX = 64;
  localparam int LINE_W_MAX  = PADDR_W_MAX - LINE_OFFS;
  localparam int RESP_W_MAX  = 2048;
  localparam int WAIT_W      = 8;

  typedef struct packed {
    logic [5:0]            transid;
    logic [LINE_W_MAX-1:0] line_addr;
    logic [WAIT_W-1:0]     wait_cnt;
  } rsp_entry_t;

  // 64-bit word i of a line is {line_addr, i[2:0]} zero-extended; word 0 is
  // the least significant word. Callers keep the low RESP_W bits.
  function automatic logic [RESP_W_MAX-1:0] line_pattern(input logic [LINE_W_MAX-1:0] line_addr);
    logic [RESP_W_MAX-1:0] d;
    d = '0;
    for (int i = 0; i < RESP_W_MAX / 64; i++) begin
      d[i*64 +: 64] = {3'b000, line_addr, 3'(i)};
    end
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tight_acc_mem_rsp_fifo.sv
// ============================================================================
// Module : tight_acc_mem_rsp_fifo
// Brief  : DEPTH-entry in-order request queue. Every stored entry counts its
//          wait counter down to zero; the head is offered for popping once
//          its counter has reached zero.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i          enqueue push_entry_i (ignored while full)
//   push_entry_i    entry to store, wait counter already initialised
//   pop_i           dequeue the head (ignored unless head_ready_o)
//   full_o          queue holds DEPTH entries
//   head_ready_o    queue non-empty and head counter is zero
//   head_o          current head entry
//   count_o         number of stored entries
// ============================================================================
`default_nettype none

module tight_acc_mem_rsp_fifo
  import tight_acc_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  rsp_entry_t                   push_entry_i,
  input  logic                         pop_i,
  output logic                         full_o,
  output logic                         head_ready_o,
  output rsp_entry_t                   head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  rsp_entry_t       entries_q [DEPTH];
  // Extra MSB distinguishes full from empty when the index bits match.
  logic [PTR_W:0]   wptr_q, wptr_d;
  logic [PTR_W:0]   rptr_q, rptr_d;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_empty      = (wptr_q == rptr_q);
  assign full_o       = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                        (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign head_o       = entries_q[rptr_q[PTR_W-1:0]];
  assign head_ready_o = !w_empty && (head_o.wait_cnt == '0);
  assign count_o      = CNT_W'(wptr_q - rptr_q);

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && head_ready_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (w_push) wptr_d = wptr_q + 1'b1;
    if (w_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      // Free slots also count down; harmless, they are overwritten on push.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (wptr_q[PTR_W-1:0] == PTR_W'(i))) begin
          entries_q[i] <= push_entry_i;
        end else if (entries_q[i].wait_cnt != '0) begin
          entries_q[i].wait_cnt <= entries_q[i].wait_cnt - 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tight_acc_mem_responder.sv
// ============================================================================
// Module : tight_acc_mem_responder
// Brief  : Memory-side stand-in for the L2/NoC behind the tight accelerator
//          port. Accepts requests, returns them in order LAT cycles later with
//          address-pattern data, or preloaded line-RAM data when
//          TIGHT_ACC_MEM_RSP_PRELOAD_EN is defined.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_req_val/rdy   request handshake
//   mem_req_transid   request id, echoed in the response
//   mem_req_addr      byte address; line = addr[PADDR_W-1:6]
//   mem_resp_val      one-cycle response strobe (no back-pressure)
//   mem_resp_transid  id of the returned request
//   mem_resp_data     line data
//   outstanding       accepted requests not yet responded
//   pl_val/idx/data   preload RAM write port (TIGHT_ACC_MEM_RSP_PRELOAD_EN)
// ============================================================================
`default_nettype none

module tight_acc_mem_responder
  import tight_acc_mem_pkg::*;
#(
  parameter int PADDR_W   = 40,
  parameter int RESP_W    = 512,
  parameter int DEPTH     = 4,
  parameter int LAT       = 8,
  parameter int RAM_LINES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mem_req_val,
  output logic                         mem_req_rdy,
  input  logic [5:0]                   mem_req_transid,
  input  logic [PADDR_W-1:0]           mem_req_addr,
  output logic                         mem_resp_val,
  output logic [5:0]                   mem_resp_transid,
  output logic [RESP_W-1:0]            mem_resp_data,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding
`ifdef TIGHT_ACC_MEM_RSP_PRELOAD_EN
  ,
  input  logic                         pl_val,
  input  logic [$clog2(RAM_LINES)-1:0] pl_idx,
  input  logic [RESP_W-1:0]            pl_data
`endif
);

  localparam int                OUT_W     = $clog2(DEPTH + 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(LAT - 1);

  logic              started_q;
  logic              w_full;
  logic              w_head_ready;
  logic              w_push;
  logic              w_pop;
  rsp_entry_t        w_push_entry;
  rsp_entry_t        w_head;
  logic [OUT_W-1:0]  w_count;
  logic [RESP_W-1:0] w_line_data;

  logic              resp_val_d,     resp_val_q;
  logic [5:0]        resp_transid_d, resp_transid_q;
  logic [RESP_W-1:0] resp_data_d,    resp_data_q;

  // started_q keeps rdy low until the first edge after reset release.
  assign mem_req_rdy = started_q && !w_full;
  assign w_push      = mem_req_val && mem_req_rdy;
  assign w_pop       = w_head_ready;

  always_comb begin
    w_push_entry           = '0;
    w_push_entry.transid   = mem_req_transid;
    w_push_entry.line_addr = LINE_W_MAX'(mem_req_addr[PADDR_W-1:LINE_OFFS]);
    w_push_entry.wait_cnt  = WAIT_INIT;
  end

  tight_acc_mem_rsp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (w_push),
    .push_entry_i (w_push_entry),
    .pop_i        (w_pop),
    .full_o       (w_full),
    .head_ready_o (w_head_ready),
    .head_o       (w_head),
    .count_o      (w_count)
  );

`ifdef TIGHT_ACC_MEM_RSP_PRELOAD_EN
  localparam int RAM_IDX_W = $clog2(RAM_LINES);

  logic [RESP_W-1:0]    ram_q [RAM_LINES];
  logic [RAM_IDX_W-1:0] w_ram_idx;
  logic                 w_unused_bits;

  // Preload RAM intentionally has no reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (pl_val) ram_q[pl_idx] <= pl_data;
  end

  assign w_ram_idx   = w_head.line_addr[RAM_IDX_W-1:0];
  // Write-first: a preload hitting the line being popped returns new data.
  assign w_line_data = (pl_val && (pl_idx == w_ram_idx)) ? pl_data : ram_q[w_ram_idx];

  assign w_unused_bits = ^{w_head.wait_cnt, w_head.line_addr[LINE_W_MAX-1:RAM_IDX_W],
                           mem_req_addr[LINE_OFFS-1:0]};
`else
  logic [RESP_W_MAX-1:0] w_pattern;
  logic                  w_unused_bits;

  assign w_pattern   = line_pattern(w_head.line_addr);
  assign w_line_data = w_pattern[RESP_W-1:0];

  assign w_unused_bits = ^{w_head.wait_cnt, w_pattern[RESP_W_MAX-1:RESP_W],
                           mem_req_addr[LINE_OFFS-1:0], (RAM_LINES > 0)};
`endif

  always_comb begin
    resp_val_d     = w_pop;
    resp_transid_d = resp_transid_q;
    resp_data_d    = resp_data_q;
    if (w_pop) begin
      resp_transid_d = w_head.transid;
      resp_data_d    = w_line_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q      <= 1'b0;
      resp_val_q     <= 1'b0;
      resp_transid_q <= '0;
      resp_data_q    <= '0;
    end else begin
      started_q      <= 1'b1;
      resp_val_q     <= resp_val_d;
      resp_transid_q <= resp_transid_d;
      resp_data_q    <= resp_data_d;
    end
  end

  assign mem_resp_val     = resp_val_q;
  assign mem_resp_transid = resp_transid_q;
  assign mem_resp_data    = resp_data_q;
  assign outstanding      = w_count;

endmodule

`default_nettype wire

// File: tb/tb_tight_acc_mem_responder.sv
// ============================================================================
// Module : tb_tight_acc_mem_responder
// Brief  : Self-checking bench for tight_acc_mem_responder. A queue-based
//          reference model predicts, per clock edge, ready, response strobe,
//          id, data and outstanding count. TIGHT_ACC_MEM_RSP_PRELOAD_EN
//          selects the preload-RAM data model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tight_acc_mem_responder;

  localparam int PADDR_W   = 40;
  localparam int RESP_W    = 512;
  localparam int DEPTH     = 4;
  localparam int LAT       = 8;
  localparam int RAM_LINES = 16;
  localparam int OUT_W     = $clog2(DEPTH + 1);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                mem_req_val = 1'b0;
  logic                mem_req_rdy;
  logic [5:0]          mem_req_transid = '0;
  logic [PADDR_W-1:0]  mem_req_addr = '0;
  logic                mem_resp_val;
  logic [5:0]          mem_resp_transid;
  logic [RESP_W-1:0]   mem_resp_data;
  logic [OUT_W-1:0]    outstanding;
`ifdef TIGHT_ACC_MEM_RSP_PRELOAD_EN
  logic                pl_val = 1'b0;
  logic [3:0]          pl_idx = '0;
  logic [RESP_W-1:0]   pl_data = '0;
  logic [RESP_W-1:0]   ram_m [RAM_LINES];
`endif

  tight_acc_mem_responder #(
    .PADDR_W   (PADDR_W),
    .RESP_W    (RESP_W),
    .DEPTH     (DEPTH),
    .LAT       (LAT),
    .RAM_LINES (RAM_LINES)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_req_val      (mem_req_val),
    .mem_req_rdy      (mem_req_rdy),
    .mem_req_transid  (mem_req_transid),
    .mem_req_addr     (mem_req_addr),
    .mem_resp_val     (mem_resp_val),
    .mem_resp_transid (mem_resp_transid),
    .mem_resp_data    (mem_resp_data),
    .outstanding      (outstanding)
`ifdef TIGHT_ACC_MEM_RSP_PRELOAD_EN
    ,
    .pl_val           (pl_val),
    .pl_idx           (pl_idx),
    .pl_data          (pl_data)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  typedef struct {
    logic [5:0]         id;
    logic [PADDR_W-1:0] addr;
    longint             pop_e;   // edge at which its response is registered
  } req_t;

  req_t              q[$];
  longint            edge_n  = 0;
  bit                started = 0;
  bit                exp_val = 0;
  logic [5:0]        exp_id  = '0;
  logic [RESP_W-1:0] exp_data = '0;
  int                checks = 0;
  int                errors = 0;
  int                peak   = 0;

  task automatic chk(input string tag, input logic [RESP_W-1:0] got, input logic [RESP_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic logic [RESP_W-1:0] exp_line(input logic [PADDR_W-1:0] a);
    logic [RESP_W-1:0] d;
    longint unsigned   ln;
    ln = longint'(a) / 64;
`ifdef TIGHT_ACC_MEM_RSP_PRELOAD_EN
    d = ram_m[ln % RAM_LINES];
`else
    for (int i = 0; i < RESP_W / 64; i++) d[i*64 +: 64] = 64'(ln * 8 + longint'(i));
`endif
    return d;
  endfunction

  task automatic check_outputs();
    chk("rdy", mem_req_rdy, started && (q.size() < DEPTH));
    chk("resp_val", mem_resp_val, exp_val);
    chk("outstanding", outstanding, q.size());
    if (exp_val) begin
      chk("resp_id", mem_resp_transid, exp_id);
      chk("resp_data", mem_resp_data, exp_data);
    end
    if (int'(outstanding) > peak) peak = int'(outstanding);
  endtask

  // Called at a negedge: drive one cycle of stimulus, advance one edge,
  // update the model and check at the following negedge.
  task automatic cyc(input bit v, input logic [5:0] id, input logic [PADDR_W-1:0] a, output bit acc);
    req_t   r;
    longint due;
    mem_req_val     = v;
    mem_req_transid = id;
    mem_req_addr    = a;
    acc = v && started && (q.size() < DEPTH) && rst_n;
    @(posedge clk);
    edge_n++;
    exp_val = 0;
    if (rst_n) begin
      if (q.size() > 0 && q[0].pop_e == edge_n) begin
        exp_val  = 1;
        exp_id   = q[0].id;
        exp_data = exp_line(q[0].addr);
        void'(q.pop_front());
      end
      if (acc) begin
        due = edge_n + LAT;
        if (q.size() > 0 && q[q.size()-1].pop_e + 1 > due) due = q[q.size()-1].pop_e + 1;
        r.id = id; r.addr = a; r.pop_e = due;
        q.push_back(r);
      end
      started = 1;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 6'd0, '0, acc);
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    mem_req_val = 1'b0;
    #1;
    q.delete();
    started = 0;
    exp_val = 0;
    chk("rst_val", mem_resp_val, 1'b0);
    chk("rst_id", mem_resp_transid, 6'd0);
    chk("rst_data", mem_resp_data, '0);
    chk("rst_out", outstanding, 0);
    chk("rst_rdy", mem_req_rdy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rdy_after_release", mem_req_rdy, 1'b0);
  endtask

  initial begin
    bit     acc;
    bit     seen;
    longint t0;
    bit     hold_v;
    logic [5:0]         hold_id;
    logic [PADDR_W-1:0] hold_a;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_val", mem_resp_val, 1'b0);
    chk("rst_rdy", mem_req_rdy, 1'b0);
    chk("rst_out", outstanding, 0);
    chk("rst_data", mem_resp_data, '0);
    rst_n = 1'b1;
    #1;
    chk("rdy_after_release", mem_req_rdy, 1'b0);
    idle(1);

`ifdef TIGHT_ACC_MEM_RSP_PRELOAD_EN
    // Load every line with random data, then line 3 with 0xA5 bytes.
    for (int i = 0; i < RAM_LINES; i++) begin
      pl_val = 1'b1; pl_idx = 4'(i);
      for (int w = 0; w < RESP_W / 32; w++) pl_data[w*32 +: 32] = $urandom;
      if (i == 3) pl_data = {(RESP_W/8){8'hA5}};
      ram_m[i] = pl_data;
      idle(1);
    end
    pl_val = 1'b0;
    cyc(1'b1, 6'd7, 40'hC0, acc);
    cyc(1'b1, 6'd8, 40'h4C0, acc);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (mem_resp_val && mem_resp_transid == 6'd8) begin
        seen = 1;
        chk("alias_data", mem_resp_data, {(RESP_W/8){8'hA5}});
      end
    end
    chk("alias_seen", seen, 1'b1);
`endif

    // Single request, latency and pattern words
    cyc(1'b1, 6'd5, 40'h1000, acc);
    t0 = edge_n;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      idle(1);
      if (mem_resp_val) begin
        seen = 1;
        chk("single_lat", 64'(edge_n - t0), 64'(LAT));
        chk("single_id", mem_resp_transid, 6'd5);
`ifndef TIGHT_ACC_MEM_RSP_PRELOAD_EN
        chk("word0", mem_resp_data[63:0], 64'h200);
        chk("word1", mem_resp_data[127:64], 64'h201);
        chk("word7", mem_resp_data[511:448], 64'h207);
`endif
      end
    end
    chk("single_seen", seen, 1'b1);
    idle(3);

    // Back-to-back ids 1..4
    peak = 0;
    for (int k = 1; k <= 4; k++) cyc(1'b1, 6'(k), 40'(k * 64), acc);
    idle(12);
    chk("b2b_peak", peak, 4);

    // Fill plus a held fifth request
    for (int k = 0; k < 4; k++) cyc(1'b1, 6'(10 + k), 40'(k * 64 + 4096), acc);
    acc = 0;
    for (int i = 0; i < 30 && !acc; i++) cyc(1'b1, 6'd9, 40'h2000, acc);
    chk("fifth_accepted", acc, 1'b1);
    idle(16);

    // Accept on the pop edge of the first of two queued requests
    cyc(1'b1, 6'd20, 40'h3000, acc);
    cyc(1'b1, 6'd21, 40'h3040, acc);
    idle(6);
    cyc(1'b1, 6'd22, 40'h3080, acc);
    idle(12);

    // Reset with three outstanding
    for (int k = 0; k < 3; k++) cyc(1'b1, 6'(30 + k), 40'(k * 64 + 8192), acc);
    mid_reset();
    idle(15);

    // Randomized traffic, initiator holds a request until accepted
    hold_v = 0; hold_id = '0; hold_a = '0;
    for (int n = 0; n < 800; n++) begin
      if (n == 400) begin
        mid_reset();
        hold_v = 0;
      end
      if (!hold_v) begin
        hold_v  = ($urandom_range(0, 99) < 60);
        hold_id = 6'($urandom);
        hold_a  = {8'($urandom), 32'($urandom)};
      end
      cyc(hold_v, hold_id, hold_a, acc);
      if (acc) hold_v = 0;
    end
    mem_req_val = 1'b0;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
